// File: rtl/jt51_pg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jt51_pg_pkg
//  Description : Shared types, latency constant and arithmetic helpers for the
//                parametrised time-multiplexed phase generator (jt51_pg_mc).
//                Optional readback port: define JT51_PG_RDBK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package jt51_pg_pkg;

    // Cycles of cen from input sampling to phase_o
    localparam int LAT = 5;

    // Per-slot control fields that ride along with the slot through the pipe
    typedef struct packed {
        logic [4:0] dt_off;
        logic       dt_neg;
        logic [3:0] mul;
        logic       pg_rst;
    } pg_ctl_t;

    // Signed add clamped to the unsigned range [0, 2^w-1]
    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint sum;
        longint max_v;
        sum   = a + b;
        max_v = (longint'(1) << w) - 1;
        if (sum < 0)
            return 0;
        else if (sum > max_v)
            return max_v;
        return sum;
    endfunction

    // Octave scaling: block 0 halves fnum, each further block doubles it
    function automatic longint blk_shift(input longint f, input int blk);
        return (f << blk) >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt51_pg_store.sv
`default_nettype none
// ============================================================================
//  Module      : jt51_pg_store
//  Description : SLOTS x PW phase store. One write port, one asynchronous read
//                port for the accumulator and, with JT51_PG_RDBK_EN defined, a
//                registered write-first readback port.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt51_pg_store #(
    parameter int SLOTS = 32,
    parameter int PW    = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(SLOTS)-1:0] waddr,
    input  logic [PW-1:0]            wdata,
    input  logic [$clog2(SLOTS)-1:0] raddr,
    output logic [PW-1:0]            rdata
`ifdef JT51_PG_RDBK_EN
    ,
    input  logic [$clog2(SLOTS)-1:0] rd_slot,
    output logic [PW-1:0]            rd_phase
`endif
);

    localparam int c_SW = $clog2(SLOTS);

    logic [PW-1:0] r_mem [SLOTS];

    // Phase array: cleared on reset, one entry rewritten per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) r_mem[i] <= '0;
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // The accumulator always addresses a legal slot, so no range guard here
    assign rdata = r_mem[raddr];

`ifdef JT51_PG_RDBK_EN
    localparam logic [c_SW:0] c_SLOTS = (c_SW+1)'(SLOTS);

    logic [PW-1:0] r_rd;

    // Debug readback, free-running on clk; a same-cycle write wins the read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rd <= '0;
        else if (we && (waddr == rd_slot))
            r_rd <= wdata;
        else if ({1'b0, rd_slot} < c_SLOTS)
            r_rd <= r_mem[rd_slot];
        else
            r_rd <= '0;
    end

    assign rd_phase = r_rd;
`endif

endmodule
`default_nettype wire

// File: rtl/jt51_pg_mc.sv
`default_nettype none
// ============================================================================
//  Module      : jt51_pg_mc
//  Description : Parametrised time-multiplexed phase generator. Five-stage
//                pipeline: fnum+PM saturation, block shift, detune, multiply,
//                accumulate into a per-slot circular store.
//                Optional full-width phase readback: define JT51_PG_RDBK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt51_pg_mc
    import jt51_pg_pkg::*;
#(
    parameter int SLOTS = 32,
    parameter int FW    = 11,
    parameter int BW    = 3,
    parameter int PW    = 20,
    parameter int OW    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cen,
    output logic [$clog2(SLOTS)-1:0] slot_I,
    output logic                     zero,
    input  logic [FW-1:0]            fnum_I,
    input  logic [BW-1:0]            block_I,
    input  logic signed [FW:0]       pm_I,
    input  logic [4:0]               dt_off_I,
    input  logic                     dt_neg_I,
    input  logic [3:0]               mul_I,
    input  logic                     pg_rst_I,
`ifdef JT51_PG_RDBK_EN
    input  logic [$clog2(SLOTS)-1:0] rd_slot,
    output logic [PW-1:0]            rd_phase,
`endif
    output logic [OW-1:0]            phase_o,
    output logic [$clog2(SLOTS)-1:0] slot_o,
    output logic                     valid_o
);

    localparam int             c_SW     = $clog2(SLOTS);
    localparam int             c_BASE_W = FW + (1 << BW) - 1;
    localparam logic [c_SW-1:0] c_LAST  = c_SW'(SLOTS - 1);

    // Slot counter and valid-fill shift register
    logic [c_SW-1:0]     r_slot;
    logic [LAT-1:0]      r_vld;

    // Stage registers
    logic [FW-1:0]       r1_f;
    logic [BW-1:0]       r1_blk;
    pg_ctl_t             r1_ctl;
    logic [c_SW-1:0]     r1_slot;
    logic [c_BASE_W-1:0] r2_base;
    pg_ctl_t             r2_ctl;
    logic [c_SW-1:0]     r2_slot;
    logic [c_BASE_W-1:0] r3_base;
    logic [3:0]          r3_mul;
    logic                r3_rst;
    logic [c_SW-1:0]     r3_slot;
    logic [PW-1:0]       r4_step;
    logic                r4_rst;
    logic [c_SW-1:0]     r4_slot;
    logic [OW-1:0]       r_phase;
    logic [c_SW-1:0]     r_slot_o;

    // Stage combinational results
    pg_ctl_t             w_ctl;
    logic [FW-1:0]       w_f;
    logic [c_BASE_W-1:0] w_base;
    logic [c_BASE_W-1:0] w_det;
    logic [PW-1:0]       w_step;
    logic [PW-1:0]       w_old;
    logic [PW-1:0]       w_new;

    // Per-stage arithmetic feeding the next pipeline register
    always_comb begin
        w_ctl.dt_off = dt_off_I;
        w_ctl.dt_neg = dt_neg_I;
        w_ctl.mul    = mul_I;
        w_ctl.pg_rst = pg_rst_I;
        w_f    = FW'(sat_add(longint'(fnum_I), longint'(pm_I), FW));
        w_base = c_BASE_W'(blk_shift(longint'(r1_f), int'(r1_blk)));
        w_det  = c_BASE_W'(sat_add(longint'(r2_base),
                                   r2_ctl.dt_neg ? -longint'(r2_ctl.dt_off)
                                                 :  longint'(r2_ctl.dt_off),
                                   c_BASE_W));
        if (r3_mul == 4'd0)
            w_step = PW'(longint'(r3_base) >> 1);
        else
            w_step = PW'(longint'(r3_base) * longint'(r3_mul));
        w_new  = r4_rst ? '0 : (w_old + r4_step);
    end

    // Slot sequencing and the five pipeline stages, all gated by cen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot   <= '0;
            r_vld    <= '0;
            r1_f     <= '0;
            r1_blk   <= '0;
            r1_ctl   <= '0;
            r1_slot  <= '0;
            r2_base  <= '0;
            r2_ctl   <= '0;
            r2_slot  <= '0;
            r3_base  <= '0;
            r3_mul   <= '0;
            r3_rst   <= 1'b0;
            r3_slot  <= '0;
            r4_step  <= '0;
            r4_rst   <= 1'b0;
            r4_slot  <= '0;
            r_phase  <= '0;
            r_slot_o <= '0;
        end else if (cen) begin
            r_slot   <= (r_slot == c_LAST) ? '0 : r_slot + 1'b1;
            r_vld    <= {r_vld[LAT-2:0], 1'b1};
            r1_f     <= w_f;
            r1_blk   <= block_I;
            r1_ctl   <= w_ctl;
            r1_slot  <= r_slot;
            r2_base  <= w_base;
            r2_ctl   <= r1_ctl;
            r2_slot  <= r1_slot;
            r3_base  <= w_det;
            r3_mul   <= r2_ctl.mul;
            r3_rst   <= r2_ctl.pg_rst;
            r3_slot  <= r2_slot;
            r4_step  <= w_step;
            r4_rst   <= r3_rst;
            r4_slot  <= r3_slot;
            r_phase  <= w_new[PW-1 -: OW];
            r_slot_o <= r4_slot;
        end
    end

    jt51_pg_store #(
        .SLOTS (SLOTS),
        .PW    (PW)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (cen),
        .waddr    (r4_slot),
        .wdata    (w_new),
        .raddr    (r4_slot),
        .rdata    (w_old)
`ifdef JT51_PG_RDBK_EN
        ,
        .rd_slot  (rd_slot),
        .rd_phase (rd_phase)
`endif
    );

    assign slot_I  = r_slot;
    assign zero    = (r_slot == '0);
    assign phase_o = r_phase;
    assign slot_o  = r_slot_o;
    assign valid_o = r_vld[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_jt51_pg_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt51_pg_mc
//  Description : Self-checking bench for jt51_pg_mc (default parameters).
//                Scoreboard of expected (slot, phase) pairs built from an
//                independent arithmetic model. Readback checks compile only
//                with JT51_PG_RDBK_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jt51_pg_mc;
    import jt51_pg_pkg::*;

    localparam int SLOTS = 32;
    localparam int FW    = 11;
    localparam int BW    = 3;
    localparam int PW    = 20;
    localparam int OW    = 10;
    localparam int SW    = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cen = 1'b0;
    logic [SW-1:0]     slot_I;
    logic              zero;
    logic [FW-1:0]     fnum_I = '0;
    logic [BW-1:0]     block_I = '0;
    logic signed [FW:0] pm_I = '0;
    logic [4:0]        dt_off_I = '0;
    logic              dt_neg_I = 1'b0;
    logic [3:0]        mul_I = '0;
    logic              pg_rst_I = 1'b0;
    logic [OW-1:0]     phase_o;
    logic [SW-1:0]     slot_o;
    logic              valid_o;
`ifdef JT51_PG_RDBK_EN
    logic [SW-1:0]     rd_slot = '0;
    logic [PW-1:0]     rd_phase;
`endif

    jt51_pg_mc #(
        .SLOTS (SLOTS), .FW (FW), .BW (BW), .PW (PW), .OW (OW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .slot_I   (slot_I),
        .zero     (zero),
        .fnum_I   (fnum_I),
        .block_I  (block_I),
        .pm_I     (pm_I),
        .dt_off_I (dt_off_I),
        .dt_neg_I (dt_neg_I),
        .mul_I    (mul_I),
        .pg_rst_I (pg_rst_I),
`ifdef JT51_PG_RDBK_EN
        .rd_slot  (rd_slot),
        .rd_phase (rd_phase),
`endif
        .phase_o  (phase_o),
        .slot_o   (slot_o),
        .valid_o  (valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] slot;
        logic [OW-1:0] phase;
    } exp_t;

    exp_t          sb[$];
    int            fnum_c[SLOTS];
    int            blk_c[SLOTS];
    int            pm_c[SLOTS];
    int            dt_c[SLOTS];
    int            neg_c[SLOTS];
    int            mul_c[SLOTS];
    bit            keyon[SLOTS];
    logic [PW-1:0] ph[SLOTS];

    int            n_cmp = 0;
    int            n_fail = 0;
    int            edges = 0;
    logic [SW-1:0] exp_slot = '0;
    logic [OW-1:0] last_ph = '0;
    logic [SW-1:0] last_sl = '0;
    logic          last_vld = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Phase step derived straight from the arithmetic description
    function automatic int model_step(input int s);
        int f;
        int b;
        int st;
        f = fnum_c[s] + pm_c[s];
        if (f < 0) f = 0;
        if (f > 2047) f = 2047;
        b = (f << blk_c[s]) >> 1;
        if (neg_c[s] != 0) begin
            b = b - dt_c[s];
            if (b < 0) b = 0;
        end else begin
            b = b + dt_c[s];
            if (b > 262143) b = 262143;
        end
        st = (mul_c[s] == 0) ? (b >> 1) : (b * mul_c[s]);
        return st % (1 << PW);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            ph[i]    = '0;
            keyon[i] = 1'b0;
        end
        sb.delete();
        edges    = 0;
        exp_slot = '0;
        last_ph  = '0;
        last_sl  = '0;
        last_vld = 1'b0;
    endtask

    task automatic set_slot(input int s, input int f, input int b, input int p,
                            input int d, input int n, input int m);
        fnum_c[s] = f; blk_c[s] = b; pm_c[s] = p;
        dt_c[s] = d; neg_c[s] = n; mul_c[s] = m;
    endtask

    task automatic do_cycle(input bit c);
        int   s;
        int   st;
        exp_t e;
        @(negedge clk);
        s        = int'(exp_slot);
        cen      = c;
        fnum_I   = FW'(fnum_c[s]);
        block_I  = BW'(blk_c[s]);
        pm_I     = (FW+1)'(pm_c[s]);
        dt_off_I = 5'(dt_c[s]);
        dt_neg_I = (neg_c[s] != 0);
        mul_I    = 4'(mul_c[s]);
        pg_rst_I = keyon[s] && c;
        check("slot_I", 64'(slot_I), 64'(exp_slot));
        check("zero", 64'(zero), 64'(exp_slot == '0));
        if (c) begin
            st = model_step(s);
            if (keyon[s]) begin
                ph[s]    = '0;
                keyon[s] = 1'b0;
            end else begin
                ph[s] = ph[s] + PW'(st);
            end
            e.slot  = exp_slot;
            e.phase = ph[s][PW-1 -: OW];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (c) begin
            edges++;
            exp_slot = (exp_slot == SW'(SLOTS - 1)) ? '0 : exp_slot + 1'b1;
            if (edges >= LAT) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 64'(sb.size()), 64'd1);
                end else begin
                    e       = sb.pop_front();
                    last_ph = e.phase;
                    last_sl = e.slot;
                end
            end
            last_vld = (edges >= LAT);
        end
        check("phase_o", 64'(phase_o), 64'(last_ph));
        check("slot_o", 64'(slot_o), 64'(last_sl));
        check("valid_o", 64'(valid_o), 64'(last_vld));
    endtask

    task automatic run(input int n, input bit c);
        for (int i = 0; i < n; i++) do_cycle(c);
    endtask

    initial begin
        for (int i = 0; i < SLOTS; i++) set_slot(i, 0, 0, 0, 0, 0, 0);
        set_slot(3,  1024, 4,    0,  0, 0, 1);   // base 8192, wraps after 128 laps
        set_slot(5,   512, 3,    0,  0, 0, 3);   // key-on target
        set_slot(7,  2040, 0,  100,  0, 0, 1);   // fnum+pm clamps high
        set_slot(8,    10, 2,  -50,  0, 0, 0);   // fnum+pm clamps to 0, x0.5
        set_slot(9,     6, 0,    0,  7, 1, 1);   // detune floors at 0
        set_slot(10,    6, 0,    0,  7, 0, 2);   // base 10, step 20
        set_slot(12, 2047, 7,    0, 31, 0, 15);  // product truncates mod 2^PW
        set_slot(31, 2047, 7, 2047, 31, 1, 0);   // max pm, negative detune, x0.5
        for (int i = 13; i <= 20; i++)
            set_slot(i, int'($urandom_range(0, 2047)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        model_reset();

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset_phase_o", 64'(phase_o), 64'd0);
        check("reset_slot_o", 64'(slot_o), 64'd0);
        check("reset_valid_o", 64'(valid_o), 64'd0);
        check("reset_slot_I", 64'(slot_I), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill and first laps
        run(3 * SLOTS, 1'b1);

        // Key-on on slot 5 mid-run
        keyon[5] = 1'b1;
        run(2 * SLOTS + 7, 1'b1);

        // Clock enable low: everything frozen
        run(10, 1'b0);

        // Irregular cen pattern
        for (int i = 0; i < 200; i++) do_cycle(1'(($urandom_range(0, 3) != 0)));

        // Long run to cover the slot 3 accumulator wrap
        run(130 * SLOTS, 1'b1);

        // Asynchronous reset mid-lap
        run(13, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_phase_o", 64'(phase_o), 64'd0);
        check("midrst_slot_o", 64'(slot_o), 64'd0);
        check("midrst_valid_o", 64'(valid_o), 64'd0);
        check("midrst_slot_I", 64'(slot_I), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cen   = 1'b0;
`ifdef JT51_PG_RDBK_EN
        for (int i = 0; i < 3; i++) begin
            rd_slot = SW'(3 + 9 * i);
            @(posedge clk);
            #1;
            check("rd_phase_after_reset", 64'(rd_phase), 64'd0);
        end
`endif

        // Restart from zero after reset
        run(3 * SLOTS, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt51_pg_mc.md
Name: jt51_pg_mc

Overview:
- Parametrised, time-multiplexed phase generator. Successor to the fixed 32-operator YM2151 phase generator.
- Converts per-slot frequency data (fnum/block, LFO phase-mod offset, detune offset, multiplier) into a phase step. Accumulates one phase per slot in an internal circular store.
- Emits the top bits of each slot's phase to the envelope/operator stage.
- Generalised in slot count, accumulator width and frequency width. Adds clock-enable stepping and per-slot phase readback.

Parameters:
- SLOTS, 32, number of time-multiplexed slots; legal range 6..64.
- FW, 11, fnum width.
- BW, 3, block (octave) width.
- PW, 20, phase accumulator width.
- OW, 10, output phase width; OW <= PW.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cen  in  1  clock enable; the pipeline, slot counter and store advance only when high.
- slot_I  out  $clog2(SLOTS)  slot whose inputs must be presented this cycle.
- zero  out  1  high when slot_I==0.
- fnum_I  in  FW  frequency number.
- block_I  in  BW  octave.
- pm_I  in  FW+1 signed  LFO phase-mod offset, added to fnum.
- dt_off_I  in  5  detune magnitude.
- dt_neg_I  in  1  1 = subtract detune.
- mul_I  in  4  multiplier; 0 means x0.5.
- pg_rst_I  in  1  key-on phase reset for this slot.
- phase_o  out  OW  phase[PW-1:PW-OW] of slot_o.
- slot_o  out  $clog2(SLOTS)  slot index of phase_o.
- valid_o  out  1  phase_o is valid.

Behaviour:
- Reset: slot counter=0, all pipeline registers=0, all SLOTS store entries=0; phase_o=0, slot_o=0, valid_o=0.
- cen low: every register and the store hold; outputs remain stable.
- Slot counter: increments on each cen cycle and wraps SLOTS-1 -> 0. Wrap-around is not power-of-two dependent.
- Pipeline: 5 cen-cycles from inputs to output. Inputs sampled at cen cycle t appear on phase_o/slot_o at cycle t+5.
  - S1: f = fnum_I + pm_I, signed. Saturate to 0 if negative; saturate to 2^FW-1 on overflow.
  - S2: base = (f << block) >> 1, width FW+2^BW-1. block=0 gives f>>1.
  - S3: detune. If dt_neg, base - dt_off with floor at 0; else base + dt_off with saturation at the all-ones base width.
  - S4: step = mul==0 ? base>>1 : base*mul. Zero-extend or truncate to PW bits (modulo).
  - S5: read store[slot]; new = pg_rst ? 0 : old+step mod 2^PW. Write new back; phase_o = new[PW-1:PW-OW].
- pg_rst and the control fields travel with their slot through the pipeline.
- pg_rst takes priority over accumulation. Output and store are both 0 for that visit. The next visit accumulates from 0.
- Each slot's store entry is read and written exactly once per SLOTS cen cycles. No read/write hazard, because SLOTS > pipeline depth.
- valid_o: low until 5 cen cycles after rst_n release, then high permanently (until the next reset).
- rst_n asserted mid-operation: immediate asynchronous clear of everything. Phases restart at 0 and the slot counter restarts at 0.
- Accumulator wrap: modulo 2^PW, with no flag.

Optional Feature:
- Macro: JT51_PG_RDBK_EN.
- With the macro defined: ports rd_slot (in, $clog2(SLOTS)) and rd_phase (out, PW) are added.
  - rd_phase is a registered full-width read of store[rd_slot], one clk latency, independent of cen.
  - When S5 writes the same slot in the same cycle, rd_phase returns the newly written value (write-first).
- Without the macro: the ports are absent and no extra read port is inferred.

Decomposition:
- Shared package jt51_pg_pkg:
  - localparam LAT=5.
  - Function for the saturating add.
  - Function for the block shift.
- Natural sub-module: jt51_pg_store, a SLOTS x PW register array with one write port and the read port(s).

Test Plan:
- Reset/fill: release rst_n with cen=1 -> valid_o=0 for 5 cycles, then 1; slot_o follows slot_I delayed 5; all phase_o=0 in the first lap.
- Basic step: SLOTS=32; slot 3 has fnum=1024, block=4, pm=0, dt_off=0, mul=1. Base=8192, so phase advances 8192 per lap; after 128 laps it wraps to 0; phase_o=8 after the first lap.
- Saturation: fnum=2040, pm=+100 -> f=2047; fnum=10, pm=-50 -> f=0. mul=0 with f=0 -> step 0 and phase constant.
- Detune floor: base=3, dt_off=7, dt_neg=1 -> step 0. dt_neg=0 -> base 10, mul=2 gives step 20 per lap.
- Key-on: pg_rst_I=1 on slot 5 mid-run -> that visit outputs 0; the next lap outputs step; other slots are unaffected.
- cen gating and async reset: cen=0 for 10 cycles -> outputs frozen. Asserting rst_n low mid-lap -> outputs 0 immediately; with RDBK_EN, rd_phase of any slot = 0 after release.
